noc_packet_checker: RTL and testbench
=====================================

Name: noc_packet_checker

Overview:
- Ejection-side endpoint for the mesh: consumes packets from a router local port and checks each one.
- It is the receive counterpart to the traffic-generating test node. It parses header flits, checks destination, sequence, length and payload pattern, and keeps saturating packet and error counters plus sticky error flags for the bench.
- It attaches in place of a test node or empty node on any mesh position.

Parameters:
DATA_WIDTH, 32, flit width; must be >= 32 (matches the NoC data width)
COORD_W, 4, width of each X/Y coordinate field
X_ID, 0, this node's X coordinate
Y_ID, 0, this node's Y coordinate

Ports:
noc_clk  in  1  single clock; all logic is on its rising edge
noc_rst_n  in  1  synchronous reset, active-low
receive_valid  in  1  flit valid from router local output
receive_ready  out  1  checker can accept a flit
receive_flit  in  DATA_WIDTH  flit data
receive_is_header  in  1  flit is a packet header
receive_is_tail  in  1  flit is a packet tail (may coincide with header)
rx_stall  in  1  bench-driven backpressure; forces receive_ready low
clear  in  1  synchronous statistics clear
pkt_count  out  8  packets completed (tail accepted), saturates at 255
err_count  out  8  packets with at least one error, saturates at 255
err_flags  out  5  sticky: [0]DEST [1]LEN [2]DATA [3]PROTO [4]SEQ
last_src  out  2*COORD_W  {src_x,src_y} of the last accepted header
busy  out  1  high while in BODY or DRAIN

Behaviour:
- Clock and reset: one clock, noc_clk; reset noc_rst_n is synchronous, active-low.
- Reset values: all outputs 0, FSM=IDLE, seq_valid=0. receive_ready is 0 while noc_rst_n=0.
- Handshake: receive_ready = !rx_stall (combinational) when out of reset. Transfer = receive_valid & receive_ready.
- Header fields, LSB first:
  - [COORD_W-1:0] dest_y
  - [2C-1:C] dest_x
  - [3C-1:2C] src_y
  - [4C-1:3C] src_x
  - [4C+7:4C] seq
  - [4C+15:4C+8] len (body flit count, 0..255)
  - Remaining bits are ignored.
- Expected body flit i (0-based): bits [15:0] = {seq,i[7:0]}; all bits above 15 = 0.
- FSM states: IDLE, BODY, DRAIN. A per-packet error register pe[4:0] is cleared on each header. The body index counter is 9 bits.
- IDLE:
  - Header transfer: latch seq, len and src; update last_src.
  - DEST error if (dest_x,dest_y) != (X_ID,Y_ID).
  - SEQ error if seq_valid and seq != exp_seq. Then exp_seq = seq+1 (mod 256) and seq_valid=1.
  - Header with is_tail: LEN error if len != 0; complete the packet. Otherwise go to BODY with idx=0.
- IDLE, non-header transfer: PROTO error. If is_tail, complete a packet; else go to DRAIN.
- BODY, body transfer:
  - DATA error on any mismatch.
  - idx increments, saturating at 256.
  - On is_tail: LEN error if idx+1 != len; complete the packet; go to IDLE.
- BODY, header transfer: PROTO error; close the current packet as errored and complete it. The new header is processed as in IDLE in the same cycle.
- DRAIN: discard flits until a tail transfer, then complete the packet and go to IDLE. No data checks are made in DRAIN.
- Completing a packet, on the cycle after the tail transfer (1-cycle latency):
  - pkt_count += 1 (saturate).
  - If pe != 0: err_count += 1 (saturate) and err_flags |= pe.
- clear: zeroes pkt_count, err_count, err_flags and seq_valid. The FSM is unaffected. If clear coincides with a packet completion, clear wins and that packet is not counted.
- Reset mid-packet: immediate return to reset state; the partial packet is never counted.
- rx_stall may toggle at any cycle. Flits are only consumed on transfer, so no flit is lost or duplicated.

Test Plan:
- X_ID=1, Y_ID=1. Send 3 packets, seq 0,1,2, len=4, dest (1,1), correct payload. -> pkt_count=3, err_count=0, err_flags=0, last_src = header src.
- Single-flit packet (header+tail) with len=0, then one with len=2 and no body. -> pkt_count=2, err_count=1, err_flags=5'b00010.
- Dest (0,1) with good payload, then a packet with body flit 2 low half = 0xFFFF. -> err_count=2, err_flags=5'b00101.
- Seq 5 then seq 7; then a body flit while IDLE followed by a tail 2 flits later. -> err_flags[4]=1 and [3]=1; pkt_count=3; busy high during DRAIN.
- rx_stall random 50% over 20 packets of len 0..16. -> pkt_count=20, err_count=0; no transfer observed while receive_ready=0.
- Assert clear on the same cycle a packet completes, and separately pulse noc_rst_n=0 mid-BODY. -> counts unchanged by that packet; all outputs 0 after reset; the next good packet gives pkt_count=1.

Source files
------------

// File: rtl/noc_packet_checker_if.sv
// Ejection-port bundle between a router local output and an endpoint.
//   master: router side, drives valid/flit/is_header/is_tail, samples ready
//   slave : endpoint side, samples the flit, drives ready
interface noc_packet_checker_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  receive_valid;
  logic                  receive_ready;
  logic [DATA_WIDTH-1:0] receive_flit;
  logic                  receive_is_header;
  logic                  receive_is_tail;

  modport master (
    output receive_valid, receive_flit, receive_is_header, receive_is_tail,
    input  receive_ready
  );

  modport slave (
    input  receive_valid, receive_flit, receive_is_header, receive_is_tail,
    output receive_ready
  );
endinterface

// File: rtl/noc_packet_checker.sv
// Ejection-side packet checker: parses header flits, checks destination,
// sequence, length and body payload pattern, and keeps saturating packet /
// error counters plus sticky error flags.
// Ports:
//   noc_clk, noc_rst_n : clock, synchronous active-low reset
//   rx                 : ejection handshake (slave side); ready = !rx_stall
//   rx_stall           : backpressure, forces rx.receive_ready low
//   clear              : zeroes statistics and the sequence tracker
//   pkt_count          : completed packets (saturating)
//   err_count          : packets with at least one error (saturating)
//   err_flags          : sticky {SEQ,PROTO,DATA,LEN,DEST}
//   last_src           : {src_x,src_y} of the last accepted header
//   busy               : packet in progress (BODY or DRAIN)
module noc_packet_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned X_ID       = 0,
  parameter int unsigned Y_ID       = 0
) (
  input  logic                   noc_clk,
  input  logic                   noc_rst_n,
  noc_packet_checker_if.slave    rx,
  input  logic                   rx_stall,
  input  logic                   clear,
  output logic [7:0]             pkt_count,
  output logic [7:0]             err_count,
  output logic [4:0]             err_flags,
  output logic [2*COORD_W-1:0]   last_src,
  output logic                   busy
);

  localparam int unsigned SEQ_LSB = 4 * COORD_W;
  localparam int unsigned LEN_LSB = SEQ_LSB + 8;
  localparam int unsigned E_DEST  = 0;
  localparam int unsigned E_LEN   = 1;
  localparam int unsigned E_DATA  = 2;
  localparam int unsigned E_PROTO = 3;
  localparam int unsigned E_SEQ   = 4;

  typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;

  state_t                  state;
  logic [4:0]              pe;
  logic [8:0]              idx;
  logic [7:0]              cur_seq;
  logic [7:0]              cur_len;
  logic [7:0]              exp_seq;
  logic                    seq_valid;
  // Two completion slots: a header arriving mid-BODY closes the open packet
  // and may itself be a single-flit packet completing in the same cycle.
  logic                    comp_a_v;
  logic [4:0]              comp_a_pe;
  logic                    comp_b_v;
  logic [4:0]              comp_b_pe;

  logic                    xfer;
  logic [DATA_WIDTH-1:0]   flit;
  logic [COORD_W-1:0]      hdr_dest_x;
  logic [COORD_W-1:0]      hdr_dest_y;
  logic [2*COORD_W-1:0]    hdr_src;
  logic [7:0]              hdr_seq;
  logic [7:0]              hdr_len;
  logic [4:0]              hdr_pe;
  logic [4:0]              body_pe;
  logic [8:0]              idx_inc;
  logic [1:0]              comp_n;
  logic [1:0]              comp_err_n;
  logic [4:0]              comp_flags;

  assign rx.receive_ready = noc_rst_n & ~rx_stall;
  assign xfer             = rx.receive_valid & rx.receive_ready;
  assign flit             = rx.receive_flit;

  assign hdr_dest_y = flit[COORD_W-1:0];
  assign hdr_dest_x = flit[2*COORD_W-1:COORD_W];
  assign hdr_src    = flit[4*COORD_W-1:2*COORD_W];
  assign hdr_seq    = flit[SEQ_LSB+7:SEQ_LSB];
  assign hdr_len    = flit[LEN_LSB+7:LEN_LSB];
  assign idx_inc    = (idx == 9'd256) ? idx : idx + 9'd1;

  // Errors detectable on a header flit alone
  always_comb begin
    hdr_pe         = '0;
    hdr_pe[E_DEST] = (hdr_dest_x != COORD_W'(X_ID)) || (hdr_dest_y != COORD_W'(Y_ID));
    hdr_pe[E_SEQ]  = seq_valid && (hdr_seq != exp_seq);
    hdr_pe[E_LEN]  = rx.receive_is_tail && (hdr_len != 8'd0);
  end

  // Errors detectable on a body flit (length only matters at the tail)
  always_comb begin
    body_pe         = '0;
    body_pe[E_DATA] = (flit[15:0] != {cur_seq, idx[7:0]}) || (flit[DATA_WIDTH-1:16] != '0);
    body_pe[E_LEN]  = rx.receive_is_tail && ((10'(idx) + 10'd1) != 10'(cur_len));
  end

  // Statistics increments from the completion slots
  always_comb begin
    comp_n     = 2'(comp_a_v) + 2'(comp_b_v);
    comp_err_n = 2'(comp_a_v && (comp_a_pe != '0)) + 2'(comp_b_v && (comp_b_pe != '0));
    comp_flags = (comp_a_v ? comp_a_pe : 5'd0) | (comp_b_v ? comp_b_pe : 5'd0);
  end

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = 9'(a) + 9'(n);
    return (s > 9'd255) ? 8'hFF : s[7:0];
  endfunction

  // Packet FSM, completion pipeline and statistics
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      pe        <= '0;
      idx       <= '0;
      cur_seq   <= '0;
      cur_len   <= '0;
      exp_seq   <= '0;
      seq_valid <= 1'b0;
      comp_a_v  <= 1'b0;
      comp_a_pe <= '0;
      comp_b_v  <= 1'b0;
      comp_b_pe <= '0;
      last_src  <= '0;
      pkt_count <= '0;
      err_count <= '0;
      err_flags <= '0;
    end else begin
      comp_a_v <= 1'b0;
      comp_b_v <= 1'b0;
      if (xfer) begin
        case (state)
          IDLE, BODY: begin
            if (rx.receive_is_header) begin
              if (state == BODY) begin
                comp_a_v  <= 1'b1;
                comp_a_pe <= pe | 5'(1 << E_PROTO);
              end
              cur_seq   <= hdr_seq;
              cur_len   <= hdr_len;
              last_src  <= hdr_src;
              exp_seq   <= hdr_seq + 8'd1;
              seq_valid <= 1'b1;
              idx       <= '0;
              if (rx.receive_is_tail) begin
                comp_b_v  <= 1'b1;
                comp_b_pe <= hdr_pe;
                pe        <= '0;
                state     <= IDLE;
                busy      <= 1'b0;
              end else begin
                pe        <= hdr_pe;
                state     <= BODY;
                busy      <= 1'b1;
              end
            end else if (state == IDLE) begin
              // Body flit with no open packet: treat as an errored packet
              if (rx.receive_is_tail) begin
                comp_b_v  <= 1'b1;
                comp_b_pe <= 5'(1 << E_PROTO);
              end else begin
                pe        <= 5'(1 << E_PROTO);
                state     <= DRAIN;
                busy      <= 1'b1;
              end
            end else begin
              idx <= idx_inc;
              if (rx.receive_is_tail) begin
                comp_b_v  <= 1'b1;
                comp_b_pe <= pe | body_pe;
                pe        <= '0;
                state     <= IDLE;
                busy      <= 1'b0;
              end else begin
                pe        <= pe | body_pe;
              end
            end
          end
          DRAIN: begin
            if (rx.receive_is_tail) begin
              comp_b_v  <= 1'b1;
              comp_b_pe <= pe;
              pe        <= '0;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end

      if (clear) begin
        pkt_count <= '0;
        err_count <= '0;
        err_flags <= '0;
        seq_valid <= 1'b0;
      end else begin
        pkt_count <= sat_add(pkt_count, comp_n);
        err_count <= sat_add(err_count, comp_err_n);
        err_flags <= err_flags | comp_flags;
      end
    end
  end

endmodule

// File: tb/tb_noc_packet_checker.sv
// Self-checking bench for noc_packet_checker (X_ID=1, Y_ID=1).
module tb_noc_packet_checker;

  logic       noc_clk;
  logic       noc_rst_n;
  logic       rx_stall;
  logic       clear;
  logic [7:0] pkt_count;
  logic [7:0] err_count;
  logic [4:0] err_flags;
  logic [7:0] last_src;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int stall_pct = 0;

  noc_packet_checker_if #(.DATA_WIDTH(32)) rif ();

  noc_packet_checker #(
    .DATA_WIDTH(32), .COORD_W(4), .X_ID(1), .Y_ID(1)
  ) dut (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .rx        (rif.slave),
    .rx_stall  (rx_stall),
    .clear     (clear),
    .pkt_count (pkt_count),
    .err_count (err_count),
    .err_flags (err_flags),
    .last_src  (last_src),
    .busy      (busy)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic settle();
    @(posedge noc_clk);
    #1;
  endtask

  // Hold one flit until it is accepted; stall randomly per stall_pct
  task automatic send_flit(input logic [31:0] f, input logic h, input logic t);
    bit done;
    int guard;
    done  = 0;
    guard = 0;
    rif.receive_valid     = 1'b1;
    rif.receive_flit      = f;
    rif.receive_is_header = h;
    rif.receive_is_tail   = t;
    while (!done) begin
      rx_stall = (stall_pct > 0) && ($urandom_range(99) < 32'(stall_pct));
      @(negedge noc_clk);
      if (stall_pct > 0) chk("ready_vs_stall", 32'(rif.receive_ready), 32'(!rx_stall));
      done = rif.receive_ready;
      @(posedge noc_clk);
      #1;
      guard++;
      if (guard > 500) begin
        $display("FAIL send_timeout actual=stuck expected=accept");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "flit never accepted");
      end
    end
    rif.receive_valid = 1'b0;
    rx_stall          = 1'b0;
  endtask

  task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy,
                          input logic [3:0] sx, input logic [3:0] sy,
                          input logic [7:0] seq, input logic [7:0] len,
                          input int nbody, input int bad);
    send_flit({len, seq, sx, sy, dx, dy}, 1'b1, nbody == 0);
    for (int i = 0; i < nbody; i++) begin
      logic [31:0] f;
      f = {16'h0, seq, 8'(i)};
      if (i == bad) f[15:0] = 16'hFFFF;
      send_flit(f, 1'b0, i == nbody - 1);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    settle();
    clear = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input logic [7:0] p, input logic [7:0] e,
                           input logic [4:0] fl);
    chk({tag, "_pkt"},   32'(pkt_count), 32'(p));
    chk({tag, "_err"},   32'(err_count), 32'(e));
    chk({tag, "_flags"}, 32'(err_flags), 32'(fl));
  endtask

  typedef struct {
    bit         clr;
    logic [3:0] dx, dy, sx, sy;
    logic [7:0] seq, len;
    int         nbody;
    int         bad;
    logic [7:0] e_pkt, e_err;
    logic [4:0] e_flags;
  } vec_t;

  vec_t vecs[7];

  // Packet-level reference: a packet's errors follow from what was sent
  int         m_pkt, m_err;
  logic [4:0] m_flags;
  bit         m_have_prev;
  logic [7:0] m_prev_seq;

  task automatic model_reset();
    m_pkt = 0; m_err = 0; m_flags = '0; m_have_prev = 0; m_prev_seq = '0;
  endtask

  task automatic model_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] seq,
                           input logic [7:0] len, input int nbody, input int bad);
    logic [4:0] pe;
    pe    = '0;
    pe[0] = !(dx == 4'd1 && dy == 4'd1);
    pe[1] = (int'(len) != nbody);
    pe[2] = (bad >= 0 && bad < nbody);
    pe[4] = m_have_prev && (seq != m_prev_seq + 8'd1);
    m_have_prev = 1;
    m_prev_seq  = seq;
    m_pkt = (m_pkt < 255) ? m_pkt + 1 : 255;
    if (pe != '0) begin
      m_err   = (m_err < 255) ? m_err + 1 : 255;
      m_flags = m_flags | pe;
    end
  endtask

  task automatic random_phase(input string tag, input int npkt, input bit inject);
    for (int n = 0; n < npkt; n++) begin
      logic [3:0] dx, sx, sy;
      logic [7:0] seq, len;
      int nbody, bad;
      dx    = 4'd1;
      sx    = 4'($urandom_range(15));
      sy    = 4'($urandom_range(15));
      len   = 8'($urandom_range(16));
      nbody = int'(len);
      bad   = -1;
      seq   = m_have_prev ? m_prev_seq + 8'd1 : 8'($urandom_range(255));
      if (inject) begin
        if ($urandom_range(9) == 0) dx = 4'd0;
        if ($urandom_range(9) == 0) seq = seq + 8'd2;
        if ($urandom_range(9) == 0) nbody = nbody + 1;
        if (nbody > 0 && $urandom_range(9) == 0) bad = int'($urandom_range(nbody - 1));
      end
      send_pkt(dx, 4'd1, sx, sy, seq, len, nbody, bad);
      model_pkt(dx, 4'd1, seq, len, nbody, bad);
      settle();
      chk_stats(tag, 8'(m_pkt), 8'(m_err), m_flags);
      chk({tag, "_src"}, 32'(last_src), 32'({sx, sy}));
    end
  endtask

  initial begin
    noc_rst_n             = 1'b0;
    rx_stall              = 1'b0;
    clear                 = 1'b0;
    rif.receive_valid     = 1'b0;
    rif.receive_flit      = '0;
    rif.receive_is_header = 1'b0;
    rif.receive_is_tail   = 1'b0;

    vecs[0] = '{1, 4'd1, 4'd1, 4'd2, 4'd3, 8'd0, 8'd4, 4, -1, 8'd1, 8'd0, 5'b00000};
    vecs[1] = '{0, 4'd1, 4'd1, 4'd2, 4'd3, 8'd1, 8'd4, 4, -1, 8'd2, 8'd0, 5'b00000};
    vecs[2] = '{0, 4'd1, 4'd1, 4'd3, 4'd2, 8'd2, 8'd4, 4, -1, 8'd3, 8'd0, 5'b00000};
    vecs[3] = '{1, 4'd1, 4'd1, 4'd5, 4'd6, 8'd0, 8'd0, 0, -1, 8'd1, 8'd0, 5'b00000};
    vecs[4] = '{0, 4'd1, 4'd1, 4'd5, 4'd6, 8'd1, 8'd2, 0, -1, 8'd2, 8'd1, 5'b00010};
    vecs[5] = '{1, 4'd0, 4'd1, 4'd7, 4'd0, 8'd0, 8'd4, 4, -1, 8'd1, 8'd1, 5'b00001};
    vecs[6] = '{0, 4'd1, 4'd1, 4'd7, 4'd1, 8'd1, 8'd4, 4,  2, 8'd2, 8'd2, 5'b00101};

    // Reset state
    repeat (3) @(posedge noc_clk);
    #1;
    chk("rst_ready", 32'(rif.receive_ready), 32'd0);
    chk_stats("rst", 8'd0, 8'd0, 5'd0);
    chk("rst_src",  32'(last_src), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    noc_rst_n = 1'b1;
    settle();
    chk("ready_out_of_reset", 32'(rif.receive_ready), 32'd1);

    // Directed packet table
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].clr) pulse_clear();
      send_pkt(vecs[v].dx, vecs[v].dy, vecs[v].sx, vecs[v].sy, vecs[v].seq, vecs[v].len,
               vecs[v].nbody, vecs[v].bad);
      settle();
      chk_stats($sformatf("vec%0d", v), vecs[v].e_pkt, vecs[v].e_err, vecs[v].e_flags);
      chk($sformatf("vec%0d_src", v), 32'(last_src), 32'({vecs[v].sx, vecs[v].sy}));
    end

    // Sequence gap, then a stray body flit that forces a drain
    pulse_clear();
    send_pkt(4'd1, 4'd1, 4'd0, 4'd0, 8'd5, 8'd0, 0, -1);
    send_pkt(4'd1, 4'd1, 4'd0, 4'd0, 8'd7, 8'd0, 0, -1);
    send_flit(32'h0000_0700, 1'b0, 1'b0);
    chk("drain_busy", 32'(busy), 32'd1);
    send_flit(32'h0000_0701, 1'b0, 1'b0);
    chk("drain_busy2", 32'(busy), 32'd1);
    send_flit(32'h0000_0702, 1'b0, 1'b1);
    chk("drain_idle", 32'(busy), 32'd0);
    settle();
    chk_stats("seqproto", 8'd3, 8'd2, 5'b11000);

    // Header mid-BODY: closes the open packet and completes a new single-flit one
    pulse_clear();
    send_flit({8'd3, 8'd10, 8'h00, 4'd1, 4'd1}, 1'b1, 1'b0);
    send_flit({16'h0, 8'd10, 8'd0}, 1'b0, 1'b0);
    chk("body_busy", 32'(busy), 32'd1);
    send_flit({8'd0, 8'd11, 8'h9A, 4'd1, 4'd1}, 1'b1, 1'b1);
    chk("latency_pkt_not_yet", 32'(pkt_count), 32'd0);
    settle();
    chk_stats("midhdr", 8'd2, 8'd1, 5'b01000);
    chk("midhdr_src", 32'(last_src), 32'h9A);

    // Random backpressure, clean traffic
    pulse_clear();
    model_reset();
    stall_pct = 50;
    random_phase("rnd_good", 20, 1'b0);
    chk_stats("rnd_good_final", 8'd20, 8'd0, 5'd0);

    // Random backpressure with injected faults
    pulse_clear();
    model_reset();
    random_phase("rnd_err", 25, 1'b1);
    stall_pct = 0;

    // Clear coinciding with a completion: that packet is not counted
    send_pkt(4'd1, 4'd1, 4'd2, 4'd2, m_prev_seq + 8'd1, 8'd1, 1, -1);
    clear = 1'b1;
    settle();
    clear = 1'b0;
    chk_stats("clr_coincide", 8'd0, 8'd0, 5'd0);
    send_pkt(4'd1, 4'd1, 4'd2, 4'd2, 8'd40, 8'd2, 2, -1);
    settle();
    chk_stats("after_clr", 8'd1, 8'd0, 5'd0);

    // Reset mid-BODY drops the partial packet
    send_pkt(4'd1, 4'd1, 4'd4, 4'd4, 8'd41, 8'd0, 0, -1);
    send_flit({8'd5, 8'd42, 8'h44, 4'd1, 4'd1}, 1'b1, 1'b0);
    send_flit({16'h0, 8'd42, 8'd0}, 1'b0, 1'b0);
    send_flit({16'h0, 8'd42, 8'd1}, 1'b0, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    noc_rst_n = 1'b0;
    settle();
    chk("midrst_ready", 32'(rif.receive_ready), 32'd0);
    chk_stats("midrst", 8'd0, 8'd0, 5'd0);
    chk("midrst_src",  32'(last_src), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    noc_rst_n = 1'b1;
    settle();
    send_pkt(4'd1, 4'd1, 4'd3, 4'd5, 8'd9, 8'd3, 3, -1);
    settle();
    chk_stats("post_rst", 8'd1, 8'd0, 5'd0);
    chk("post_rst_src", 32'(last_src), 32'h35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
